// File: rtl/regfile_loader.sv
// Byte-stream register preloader: assembles little-endian words, writes them into
// r[FIRST_REG..LAST_REG] through the regfile write port and verifies an XOR checksum.
module regfile_loader #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        ld_active,
    output logic        ld_we,
    output logic [4:0]  ld_rd,
    output logic [31:0] ld_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  reg_idx_reg, reg_idx_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [7:0]  chk_reg, chk_next;
    logic [31:0] word_reg, word_next;
    logic [4:0]  ld_rd_reg, ld_rd_next;
    logic [31:0] ld_data_reg, ld_data_next;
    logic        accept_data;
    logic [3:0]  lane_sel;

    assign accept_data = (state_reg == S_COLLECT) && in_valid;

    // One byte lane per position; only the lane addressed by byte_cnt captures.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_sel[gi] = accept_data && (byte_cnt_reg == 2'(gi));
            assign word_next[8*gi +: 8] = lane_sel[gi] ? in_data : word_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        reg_idx_next  = reg_idx_reg;
        byte_cnt_next = byte_cnt_reg;
        chk_next      = chk_reg;
        ld_rd_next    = ld_rd_reg;
        ld_data_next  = ld_data_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next    = S_COLLECT;
                    reg_idx_next  = FIRST_IDX;
                    byte_cnt_next = 2'd0;
                    chk_next      = 8'd0;
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    chk_next      = chk_reg ^ in_data;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    // Write address/data are latched here so they hold after WRITE.
                    if (lane_sel[3]) begin
                        state_next   = S_WRITE;
                        ld_rd_next   = reg_idx_reg;
                        ld_data_next = word_next;
                    end
                end
            end
            S_WRITE: begin
                if (reg_idx_reg == LAST_IDX) begin
                    state_next = S_CHECK;
                end else begin
                    reg_idx_next = reg_idx_reg + 5'd1;
                    state_next   = S_COLLECT;
                end
            end
            S_CHECK: begin
                if (in_valid) begin
                    state_next = (in_data == chk_reg) ? S_DONE : S_ERR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            reg_idx_reg  <= FIRST_IDX;
            byte_cnt_reg <= 2'd0;
            chk_reg      <= 8'd0;
            word_reg     <= 32'd0;
            ld_rd_reg    <= 5'd0;
            ld_data_reg  <= 32'd0;
        end else begin
            state_reg    <= state_next;
            reg_idx_reg  <= reg_idx_next;
            byte_cnt_reg <= byte_cnt_next;
            chk_reg      <= chk_next;
            word_reg     <= word_next;
            ld_rd_reg    <= ld_rd_next;
            ld_data_reg  <= ld_data_next;
        end
    end

    assign in_ready  = (state_reg == S_COLLECT) || (state_reg == S_CHECK);
    assign ld_we     = (state_reg == S_WRITE);
    assign ld_active = (state_reg == S_COLLECT) || (state_reg == S_WRITE) || (state_reg == S_CHECK);
    assign cpu_hold  = ld_active || (state_reg == S_ERR);
    assign done      = (state_reg == S_DONE);
    assign err       = (state_reg == S_ERR);
    assign ld_rd     = ld_rd_reg;
    assign ld_data   = ld_data_reg;

endmodule

// File: tb/tb_regfile_loader.sv
// Randomized self-checking bench for regfile_loader: a word-level model predicts the
// register writes and checksum outcome; a simple regfile captures what the DUT writes.
module tb_regfile_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        ld_active;
    logic        ld_we;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_we = -1;
    bit cadence_on = 1'b0;

    logic [31:0] word_mem [1:31];
    logic [31:0] rf [0:31];
    logic [4:0]  exp_rd_q [$];
    logic [31:0] exp_data_q [$];
    logic [4:0]  er;
    logic [31:0] ed;

    regfile_loader #(.FIRST_REG(1), .LAST_REG(31)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ld_active(ld_active), .ld_we(ld_we), .ld_rd(ld_rd), .ld_data(ld_data),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Regfile model and write-port monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset && ld_active)
            check("ready_vs_we", {31'd0, in_ready}, {31'd0, !ld_we});
        if (ld_we) begin
            if (exp_rd_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                er = exp_rd_q.pop_front();
                ed = exp_data_q.pop_front();
                check("ld_rd", {27'd0, ld_rd}, {27'd0, er});
                check("ld_data", ld_data, ed);
            end
            check("hold_in_write", {31'd0, cpu_hold}, 32'd1);
            if (cadence_on && last_we >= 0)
                check("cadence", 32'(cyc - last_we), 32'd5);
            last_we = cyc;
            rf[ld_rd] = ld_data;
            $display("write r%0d = %h", ld_rd, ld_data);
        end
    end

    task automatic reset_dut();
        reset = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b, input int gap);
        int n;
        logic rdy;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data = b;
        n = 0;
        forever begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            #1;
            if (rdy) break;
            n++;
            if (n > 50) begin
                check("handshake_timeout", 32'd1, 32'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check("start_state", {29'd0, in_ready, done, err}, 32'b100);
    endtask

    // Full load: expected writes are word_mem[1..31] in order, checksum is the XOR of all bytes.
    task automatic run_load(input int maxgap, input bit bad_sum, input bit cadence);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'd0;
        for (int k = 0; k < 32; k++) rf[k] = 32'h5A5A_0000 | k;
        last_we = -1;
        cadence_on = cadence;
        pulse_start();
        for (int r = 1; r <= 31; r++) begin
            exp_rd_q.push_back(5'(r));
            exp_data_q.push_back(word_mem[r]);
            for (int i = 0; i < 4; i++) begin
                b = word_mem[r][8*i +: 8];
                sum = sum ^ b;
                drive_byte(b, (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
            end
        end
        drive_byte(bad_sum ? ~sum : sum, 0);
        cadence_on = 1'b0;
        check("done", {31'd0, done}, {31'd0, !bad_sum});
        check("err", {31'd0, err}, {31'd0, bad_sum});
        check("cpu_hold", {31'd0, cpu_hold}, {31'd0, bad_sum});
        check("ld_active_off", {31'd0, ld_active}, 32'd0);
        check("all_writes_seen", exp_rd_q.size(), 32'd0);
        for (int k = 1; k <= 31; k++) check("readback", rf[k], word_mem[k]);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();
        check("reset_outs", {26'd0, in_ready, ld_active, ld_we, cpu_hold, done, err}, 32'd0);
        check("reset_rd", {27'd0, ld_rd}, 32'd0);
        check("reset_data", ld_data, 32'd0);

        // Idle with valid stream and no start: nothing may happen.
        in_valid = 1'b1;
        repeat (10) begin
            in_data = 8'($urandom);
            @(posedge clock);
            #1 check("idle_quiet", {28'd0, in_ready, ld_we, done, err}, 32'd0);
        end
        in_valid = 1'b0;

        // r_k = k, checksum good, gap-free.
        for (int k = 1; k <= 31; k++) word_mem[k] = 32'(k);
        run_load(0, 1'b0, 1'b1);

        // Same stream with a wrong checksum byte.
        run_load(0, 1'b1, 1'b0);

        // Random words starting with DEADBEEF, random idle gaps between bytes; restart from ERR.
        for (int k = 1; k <= 31; k++) word_mem[k] = $urandom;
        word_mem[1] = 32'hDEADBEEF;
        run_load(3, 1'b0, 1'b0);

        // Continuous valid stream with random words: fixed 5-cycle write cadence.
        for (int k = 1; k <= 31; k++) word_mem[k] = $urandom;
        run_load(0, 1'b0, 1'b1);

        // Reset after r5 and two bytes of r6.
        for (int k = 1; k <= 31; k++) word_mem[k] = $urandom;
        pulse_start();
        for (int r = 1; r <= 5; r++) begin
            exp_rd_q.push_back(5'(r));
            exp_data_q.push_back(word_mem[r]);
            for (int i = 0; i < 4; i++) drive_byte(word_mem[r][8*i +: 8], 0);
        end
        drive_byte(word_mem[6][7:0], 0);
        drive_byte(word_mem[6][15:8], 0);
        reset = 1'b1;
        @(posedge clock);
        #1 check("abort_outs", {26'd0, in_ready, ld_active, ld_we, cpu_hold, done, err}, 32'd0);
        check("abort_rd", {27'd0, ld_rd}, 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 check("abort_writes", exp_rd_q.size(), 32'd0);
        run_load(2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
